// File: rtl/cache_port_arbiter.sv
// ----------------------------------------------------------------------------
// cache_port_arbiter
//
// Shares one single-ported cache between two requesters: port 0 (fetch) and
// port 1 (load/store). One transaction is in flight at a time. When both
// ports request in the same IDLE cycle, round-robin priority picks the
// winner. The winning address/data/write-enable are registered onto the
// cache inputs. A write occupies the cache for one ISSUE cycle. A read waits
// RD_LAT cycles and then returns c_q to the owning port as a registered
// value with a one-cycle valid pulse.
//
// Parameters
//   DATA_W  data width of the cache (c_data / c_q / q0 / q1)
//   ADDR_W  address width
//   RD_LAT  cycles from c_addr being driven to c_q being valid (1..4)
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req0/wr0/addr0/data0     port 0 request (held stable until gnt0)
//   gnt0                     pulse: port 0 request captured
//   rvalid0, q0              pulse + registered read data for port 0
//   req1 ... q1              same for port 1
//   c_data, c_addr, c_wr     registered drive into the cache
//   c_q                      read data from the cache
// ----------------------------------------------------------------------------
module cache_port_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              req0,
   input  logic              wr0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] data0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] q0,

   input  logic              req1,
   input  logic              wr1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] data1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] q1,

   output logic [DATA_W-1:0] c_data,
   output logic [ADDR_W-1:0] c_addr,
   output logic              c_wr,
   input  logic [DATA_W-1:0] c_q
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Counter preload for the WAIT phase; RD_LAT of at most 4 fits in 2 bits.
   localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

   state_t            state, state_nx;
   logic              prio,  prio_nx;    // port favoured on a tie
   logic              owner, owner_nx;   // port that owns the transaction
   logic [1:0]        cnt,   cnt_nx;     // remaining WAIT cycles

   logic              gnt0_nx, gnt1_nx;
   logic              rvalid0_nx, rvalid1_nx;
   logic [DATA_W-1:0] q0_nx, q1_nx;
   logic [DATA_W-1:0] c_data_nx;
   logic [ADDR_W-1:0] c_addr_nx;
   logic              c_wr_nx;

   // Port 1 wins when it is the only requester, or when both request and it
   // holds priority.
   logic              pick1;
   assign pick1 = req1 & (~req0 | prio);

   // -------------------------------------------------------------------------
   // Next-state and next-output logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so that no path
      // leaves a variable unassigned, which would infer a latch.
      state_nx   = state;
      prio_nx    = prio;
      owner_nx   = owner;
      cnt_nx     = cnt;
      c_addr_nx  = c_addr;
      c_data_nx  = c_data;
      c_wr_nx    = 1'b0;
      gnt0_nx    = 1'b0;
      gnt1_nx    = 1'b0;
      rvalid0_nx = 1'b0;
      rvalid1_nx = 1'b0;
      q0_nx      = q0;
      q1_nx      = q1;

      unique case (state)
         IDLE: begin
            // Requests are only looked at here; anything raised while busy
            // is simply re-evaluated once the arbiter returns to IDLE.
            if (req0 || req1) begin
               owner_nx  = pick1;
               c_addr_nx = pick1 ? addr1 : addr0;
               c_data_nx = pick1 ? data1 : data0;
               c_wr_nx   = pick1 ? wr1   : wr0;
               gnt0_nx   = ~pick1;
               gnt1_nx   = pick1;
               prio_nx   = ~pick1;
               state_nx  = ISSUE;
            end
         end

         ISSUE: begin
            // c_wr still carries the captured write flag during ISSUE, so it
            // doubles as the read/write discriminator for this transaction.
            if (c_wr) begin
               state_nx = IDLE;
            end else begin
               cnt_nx   = LAT_M1;
               state_nx = (RD_LAT == 1) ? RESP : WAIT;
            end
         end

         WAIT: begin
            cnt_nx = cnt - 2'd1;
            if (cnt_nx == 2'd0) begin
               state_nx = RESP;
            end
         end

         RESP: begin
            // c_q is valid this cycle; hand it to the owning port only, so
            // the other port's last read data is left untouched.
            if (owner) begin
               q1_nx      = c_q;
               rvalid1_nx = 1'b1;
            end else begin
               q0_nx      = c_q;
               rvalid0_nx = 1'b1;
            end
            state_nx = IDLE;
         end

         default: state_nx = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // State and output registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed above, independent of statement
   // order.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the read-data holding registers are ordinary flops, not a
         // memory, so they are cleared along with everything else; all
         // outputs read 0 after reset.
         state   <= IDLE;
         prio    <= 1'b0;
         owner   <= 1'b0;
         cnt     <= 2'd0;
         c_addr  <= '0;
         c_data  <= '0;
         c_wr    <= 1'b0;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         q0      <= '0;
         q1      <= '0;
      end else begin
         state   <= state_nx;
         prio    <= prio_nx;
         owner   <= owner_nx;
         cnt     <= cnt_nx;
         c_addr  <= c_addr_nx;
         c_data  <= c_data_nx;
         c_wr    <= c_wr_nx;
         gnt0    <= gnt0_nx;
         gnt1    <= gnt1_nx;
         rvalid0 <= rvalid0_nx;
         rvalid1 <= rvalid1_nx;
         q0      <= q0_nx;
         q1      <= q1_nx;
      end
   end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cache_port_arbiter
//
// Drives both ports of cache_port_arbiter in front of a behavioural cache with
// RD_LAT cycles of read latency. A transaction-level reference model, updated
// once per cycle from the request lines, predicts every grant (port, cycle,
// cache drive) and every read return (port, cycle, data) and pushes them into
// queues; the same negedge process pops and compares whenever a grant or
// read return is due or shows up.
// ----------------------------------------------------------------------------
module tb_cache_port_arbiter;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int RD_LAT = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [1:0]        req = 2'b00;
   logic [1:0]        wr  = 2'b00;
   logic [ADDR_W-1:0] addr [2];
   logic [DATA_W-1:0] data [2];

   logic              gnt0, gnt1, rvalid0, rvalid1, c_wr;
   logic [DATA_W-1:0] q0, q1, c_data, c_q;
   logic [ADDR_W-1:0] c_addr;
   wire  [1:0]        gnt_v = {gnt1, gnt0};

   cache_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
      .clk     (clk),
      .rst     (rst),
      .req0    (req[0]),
      .wr0     (wr[0]),
      .addr0   (addr[0]),
      .data0   (data[0]),
      .gnt0    (gnt0),
      .rvalid0 (rvalid0),
      .q0      (q0),
      .req1    (req[1]),
      .wr1     (wr[1]),
      .addr1   (addr[1]),
      .data1   (data[1]),
      .gnt1    (gnt1),
      .rvalid1 (rvalid1),
      .q1      (q1),
      .c_data  (c_data),
      .c_addr  (c_addr),
      .c_wr    (c_wr),
      .c_q     (c_q)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Initial memory image shared by the cache model and the reference model.
   function automatic logic [DATA_W-1:0] init_val(input int i);
      if (i == 16) return 32'h0000_DEAD;
      return 32'hA500_0000 ^ DATA_W'(i * 32'h0001_0101);
   endfunction

   // -------------------------------------------------------------------------
   // Behavioural cache: synchronous write, read data RD_LAT cycles after the
   // address is presented.
   // -------------------------------------------------------------------------
   logic [DATA_W-1:0] cmem  [256];
   logic [7:0]        apipe [RD_LAT];
   logic              cinit = 1'b1;

   always @(posedge clk) begin
      if (cinit) begin
         for (int i = 0; i < 256; i++) cmem[i] <= init_val(i);
         cinit <= 1'b0;
      end else if (c_wr) begin
         cmem[c_addr[7:0]] <= c_data;
      end
      apipe[0] <= c_addr[7:0];
      for (int i = 1; i < RD_LAT; i++) apipe[i] <= apipe[i-1];
   end
   assign c_q = cmem[apipe[RD_LAT-1]];

   // -------------------------------------------------------------------------
   // Reference model and scoreboard
   // -------------------------------------------------------------------------
   typedef struct {
      int                cyc;
      logic              port;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } gnt_t;

   typedef struct {
      int                cyc;
      logic              port;
      logic [DATA_W-1:0] data;
   } rd_t;

   gnt_t              gq [$];
   rd_t               rq [$];
   logic [DATA_W-1:0] ref_mem [256];
   logic [DATA_W-1:0] exp_q [2];
   logic              prio     = 1'b0;
   int                idle_at  = 0;
   int                hold_from = 0;
   int                hold_to   = -1;
   logic [ADDR_W-1:0] hold_addr;
   bit                rst_prev = 1'b0;
   bit                armed    = 1'b0;
   bit                ref_ready = 1'b0;
   bit                done     = 1'b0;
   int                tmo_cnt  = 0;
   int                vectors  = 0;
   int                miscompares = 0;

   gnt_t              ge;
   rd_t               re;
   logic [1:0]        eg, er;
   logic              ewr, w;

   task automatic check(input string name, input logic [255:0] act,
                        input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!ref_ready) begin
         for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
         exp_q[0]  = '0;
         exp_q[1]  = '0;
         ref_ready = 1'b1;
      end

      if (rst_prev) begin
         check("reset_outputs",
               {gnt0, gnt1, rvalid0, rvalid1, c_wr, c_addr, c_data, q0, q1}, '0);
         armed = 1'b1;
      end

      if (armed) begin
         // Grant side: pop when a grant is due or when the DUT shows one.
         eg  = 2'b00;
         ewr = 1'b0;
         if (gq.size() > 0 && (gq[0].cyc <= cyc || gnt_v != 2'b00)) begin
            ge = gq.pop_front();
            check("gnt_cycle", 256'(cyc), 256'(ge.cyc));
            eg[ge.port] = 1'b1;
            ewr = ge.wr;
            check("gnt_c_addr", c_addr, ge.addr);
            check("gnt_c_data", c_data, ge.data);
         end
         check("gnt", gnt_v, eg);
         check("c_wr", c_wr, ewr);

         if (cyc >= hold_from && cyc <= hold_to) check("c_addr_hold", c_addr, hold_addr);

         // Read-return side.
         er = 2'b00;
         if (rq.size() > 0 && (rq[0].cyc <= cyc || rvalid0 || rvalid1)) begin
            re = rq.pop_front();
            check("rvalid_cycle", 256'(cyc), 256'(re.cyc));
            er[re.port]    = 1'b1;
            exp_q[re.port] = re.data;
         end
         check("rvalid", {rvalid1, rvalid0}, er);
         check("q0", q0, exp_q[0]);
         check("q1", q1, exp_q[1]);
      end

      // Model update for the requests presented in this cycle.
      if (rst) begin
         gq.delete();
         rq.delete();
         prio     = 1'b0;
         idle_at  = cyc + 1;
         hold_to  = -1;
         exp_q[0] = '0;
         exp_q[1] = '0;
      end else if (cyc >= idle_at && req != 2'b00) begin
         w = (req == 2'b11) ? prio : req[1];
         gq.push_back('{cyc + 1, w, wr[w], addr[w], data[w]});
         prio = ~w;
         if (wr[w]) begin
            ref_mem[addr[w][7:0]] = data[w];
            idle_at = cyc + 2;
         end else begin
            rq.push_back('{cyc + 2 + RD_LAT, w, ref_mem[addr[w][7:0]]});
            idle_at   = cyc + 2 + RD_LAT;
            hold_from = cyc + 1;
            hold_to   = cyc + 1 + RD_LAT;
            hold_addr = addr[w];
         end
      end
      rst_prev = rst;

      if (done || cyc > 40000) begin
         if (!done) $display("FAIL watchdog: stimulus did not finish by cycle %0d", cyc);
         check("watchdog", 256'(done), 256'(1));
         check("drain", 256'(gq.size() + rq.size()), '0);
         check("req_timeouts", 256'(tmo_cnt), '0);
         $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
         $finish;
      end
   end

   // -------------------------------------------------------------------------
   // Stimulus
   // -------------------------------------------------------------------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present a request on port p and hold it until the grant is seen.
   task automatic do_req(input int p, input logic w_i,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      int n;
      wr[p]   = w_i;
      addr[p] = a;
      data[p] = d;
      req[p]  = 1'b1;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!gnt_v[p] && n < 400);
      if (!gnt_v[p]) begin
         $display("FAIL req_timeout port %0d: no grant within %0d cycles", p, n);
         tmo_cnt++;
      end
      req[p] = 1'b0;
   endtask

   task automatic rand_port(input int p, input int n);
      for (int i = 0; i < n; i++) begin
         tick($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) begin
            // Short request that is withdrawn after one cycle.
            wr[p]   = 1'($urandom_range(0, 1));
            addr[p] = ADDR_W'(32'h20 + $urandom_range(0, 15));
            data[p] = $urandom;
            req[p]  = 1'b1;
            tick(1);
            req[p]  = 1'b0;
         end else begin
            do_req(p, 1'($urandom_range(0, 1)),
                   ADDR_W'(32'h20 + $urandom_range(0, 15)), $urandom);
         end
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   initial begin
      addr[0] = '0; addr[1] = '0;
      data[0] = '0; data[1] = '0;
      tick(3);
      rst = 1'b0;
      tick(2);

      // Single write then read on port 0.
      do_req(0, 1'b1, 32'h0, 32'h1);
      do_req(0, 1'b0, 32'h0, 32'h0);
      tick(RD_LAT + 3);

      // Simultaneous reads straight after reset: port 0 must go first.
      pulse_reset();
      tick(1);
      fork
         do_req(0, 1'b0, 32'h4, 32'h0);
         do_req(1, 1'b0, 32'h8, 32'h0);
      join
      tick(RD_LAT + 3);

      // Sustained write contention: grants alternate.
      fork
         for (int i = 0; i < 6; i++) do_req(0, 1'b1, ADDR_W'(32'h40 + i), $urandom);
         for (int j = 0; j < 6; j++) do_req(1, 1'b1, ADDR_W'(32'h50 + j), $urandom);
      join
      tick(2);

      // Port 1 reads the preloaded 0xDEAD; q0 must stay put.
      do_req(1, 1'b0, 32'h10, 32'h0);
      tick(RD_LAT + 3);

      // Reset in the WAIT phase of a port 0 read, then a lone port 1 read.
      do_req(0, 1'b0, 32'h11, 32'h0);
      tick(1);
      pulse_reset();
      do_req(1, 1'b0, 32'h12, 32'h0);
      tick(RD_LAT + 3);

      // Port 1 raises and withdraws a request while a port 0 read is busy.
      do_req(0, 1'b0, 32'h24, 32'h0);
      wr[1]   = 1'b0;
      addr[1] = 32'h30;
      req[1]  = 1'b1;
      tick(2);
      req[1]  = 1'b0;
      tick(RD_LAT + 4);

      // Randomised traffic on both ports.
      fork
         rand_port(0, 50);
         rand_port(1, 50);
      join
      tick(RD_LAT + 4);

      done = 1'b1;
   end

endmodule
